// File: rtl/max_search_ctrl_pkg.sv
// rtl/max_search_ctrl_pkg.sv - shared state encoding and sizing constants for the max-search sequencer
package max_search_ctrl_pkg;

    localparam int FLOAT_W       = 32;
    localparam int MEL_FRAME_LEN = 26;
    localparam int CMP_LATENCY   = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCEPT  = 3'd1,
        ST_COMPARE = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/max_search_ctrl_compare.sv
// rtl/max_search_ctrl_compare.sv - 3-cycle magnitude compare of two float32 operands, returns the larger
module max_pair_compare #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_01,
    input  logic [DATA_WIDTH-1:0] input_02,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] s1_a, s1_b, s2_a, s2_b;
    logic                  s2_sel_a;

    // Sign bit is excluded; equal magnitudes select input_02 so the later sample wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_a     <= '0;
            s1_b     <= '0;
            s2_a     <= '0;
            s2_b     <= '0;
            s2_sel_a <= 1'b0;
            result   <= '0;
        end else begin
            s1_a     <= input_01;
            s1_b     <= input_02;
            s2_a     <= s1_a;
            s2_b     <= s1_b;
            s2_sel_a <= s1_a[DATA_WIDTH-2:0] > s1_b[DATA_WIDTH-2:0];
            result   <= s2_sel_a ? s2_a : s2_b;
        end
    end

endmodule

// File: rtl/max_search_ctrl.sv
// rtl/max_search_ctrl.sv - serial frame max-search sequencer returning peak value and its index
module max_search_ctrl #(
    parameter int DATA_WIDTH  = max_search_ctrl_pkg::FLOAT_W,
    parameter int FRAME_LEN   = max_search_ctrl_pkg::MEL_FRAME_LEN,
    parameter int IDX_WIDTH   = 5,
    parameter int CMP_LATENCY = max_search_ctrl_pkg::CMP_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] max_data,
    output logic [IDX_WIDTH-1:0]  max_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);
    import max_search_ctrl_pkg::*;

    localparam int CNT_W = IDX_WIDTH + 1;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [2:0]            wcnt;
    logic [DATA_WIDTH-1:0] acc, cand, cmp_result;
    logic [IDX_WIDTH-1:0]  acc_idx, cand_idx;
    logic                  cand_won;

    // acc/cand are registers held constant through COMPARE, satisfying the unit's stable-operand rule.
    max_pair_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .clk      (clk),
        .rst_n    (~rst),
        .input_01 (acc),
        .input_02 (cand),
        .result   (cmp_result)
    );

    assign cand_won = (cmp_result == cand);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            max_data  <= '0;
            max_idx   <= '0;
            cnt       <= '0;
            wcnt      <= '0;
            acc       <= '0;
            acc_idx   <= '0;
            cand      <= '0;
            cand_idx  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc     <= in_data;
                        acc_idx <= '0;
                        cnt     <= CNT_W'(1);
                        busy    <= 1'b1;
                        if (FRAME_LEN == 1) begin
                            state     <= ST_DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            max_data  <= in_data;
                            max_idx   <= '0;
                        end else begin
                            state <= ST_ACCEPT;
                        end
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid) begin
                        cand     <= in_data;
                        cand_idx <= cnt[IDX_WIDTH-1:0];
                        wcnt     <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    wcnt <= wcnt + 3'd1;
                    if (wcnt == 3'(CMP_LATENCY - 1))
                        state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    acc <= cmp_result;
                    if (cand_won)
                        acc_idx <= cand_idx;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt + CNT_W'(1) == CNT_W'(FRAME_LEN)) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        max_data  <= cmp_result;
                        max_idx   <= cand_won ? cand_idx : acc_idx;
                    end else begin
                        state    <= ST_ACCEPT;
                        in_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        cnt       <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_max_search_ctrl.sv
// tb/tb_max_search_ctrl.sv - self-checking bench for max_search_ctrl
module tb_max_search_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] in_data;
    logic        in_valid, in_ready;
    logic [31:0] max_data;
    logic [4:0]  max_idx;
    logic        out_valid, out_ready, busy;

    logic [31:0] d1_in_data;
    logic        d1_in_valid, d1_in_ready;
    logic [31:0] d1_max_data;
    logic [0:0]  d1_max_idx;
    logic        d1_out_valid, d1_out_ready, d1_busy;

    max_search_ctrl #(.DATA_WIDTH(32), .FRAME_LEN(26), .IDX_WIDTH(5), .CMP_LATENCY(3)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .max_data(max_data), .max_idx(max_idx), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy)
    );

    max_search_ctrl #(.DATA_WIDTH(32), .FRAME_LEN(1), .IDX_WIDTH(1), .CMP_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst), .in_data(d1_in_data), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .max_data(d1_max_data), .max_idx(d1_max_idx), .out_valid(d1_out_valid),
        .out_ready(d1_out_ready), .busy(d1_busy)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          t_first = 0;
    int          lat;
    logic [31:0] frame [26];
    logic [31:0] exp_data;
    logic [4:0]  exp_idx;
    bit          exp_armed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic logic [31:0] i2f(input int n);
        int          p;
        logic [31:0] m;
        p = 0;
        for (int b = 0; b < 31; b++)
            if (n[b]) p = b;
        m = (32'(n) << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // Largest magnitude wins; on equal magnitude the later sample replaces the earlier one.
    task automatic model(input int n);
        exp_data = frame[0];
        exp_idx  = '0;
        for (int i = 1; i < n; i++)
            if (frame[i][30:0] >= exp_data[30:0]) begin
                exp_data = frame[i];
                exp_idx  = 5'(i);
            end
        exp_armed = 1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!exp_armed) begin
                chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("cmp_max_data", max_data, exp_data);
                chk("cmp_max_idx", {27'd0, max_idx}, {27'd0, exp_idx});
                chk("cmp_busy", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic send_frame(input int n, input int gap_mul);
        for (int i = 0; i < n; i++) begin
            int t;
            in_data  = frame[i];
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                fail_now("accept");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            if (i == 0) t_first = cyc;
            in_valid = 1'b0;
            if (gap_mul != 0 && i < n - 1)
                repeat ((i * gap_mul) % 8) @(negedge clk);
        end
    endtask

    task automatic wait_out(output int latency);
        int t;
        t = 0;
        while (!out_valid && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) fail_now("out_valid");
        latency = cyc - t_first;
    endtask

    task automatic release_out(input int hold);
        repeat (hold) begin
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_armed = 0;
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("release_busy", {31'd0, busy}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        d1_in_valid = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_max_data", max_data, 32'd0);
        chk("rst_max_idx", {27'd0, max_idx}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ascending 1..26 at full rate: also pins first-accept-to-out_valid latency.
        for (int i = 0; i < 26; i++) frame[i] = i2f(i + 1);
        model(26);
        chk("model_asc_data", exp_data, 32'h41D0_0000);
        send_frame(26, 0);
        wait_out(lat);
        chk("asc_latency", 32'(lat), 32'd125);
        chk("asc_max_data", max_data, 32'h41D0_0000);
        chk("asc_max_idx", {27'd0, max_idx}, 32'd25);
        release_out(2);

        for (int i = 0; i < 26; i++) frame[i] = (i == 0) ? i2f(100) : i2f(1);
        model(26);
        chk("model_first_data", exp_data, 32'h42C8_0000);
        send_frame(26, 0);
        wait_out(lat);
        chk("first_max_data", max_data, 32'h42C8_0000);
        chk("first_max_idx", {27'd0, max_idx}, 32'd0);
        release_out(1);

        for (int i = 0; i < 26; i++) frame[i] = i2f(2);
        model(26);
        chk("model_tie_idx", {27'd0, exp_idx}, 32'd25);
        send_frame(26, 0);
        wait_out(lat);
        chk("tie_max_data", max_data, 32'h4000_0000);
        chk("tie_max_idx", {27'd0, max_idx}, 32'd25);
        release_out(1);

        // Scrambled magnitudes, sign set on even indices, gaps 0..7, slow consumer.
        for (int i = 0; i < 26; i++)
            frame[i] = i2f((i * 7) % 26 + 1) | ((i % 2 == 0) ? 32'h8000_0000 : 32'h0);
        model(26);
        chk("model_gap_idx", {27'd0, exp_idx}, 32'd11);
        send_frame(26, 5);
        wait_out(lat);
        chk("gap_max_data", max_data, 32'h41D0_0000);
        release_out(10);

        for (int i = 0; i < 26; i++) frame[i] = (i == 9) ? 32'h40F0_0000 : i2f(3);
        send_frame(12, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);
        model(26);
        send_frame(26, 0);
        wait_out(lat);
        chk("midrst_max_data", max_data, 32'h40F0_0000);
        chk("midrst_max_idx", {27'd0, max_idx}, 32'd9);
        release_out(1);

        // Single-sample frame build: result must appear the cycle after the accept.
        d1_in_data  = 32'h40A0_0000;
        d1_in_valid = 1'b1;
        chk("d1_in_ready", {31'd0, d1_in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        d1_in_valid = 1'b0;
        chk("d1_out_valid", {31'd0, d1_out_valid}, 32'd1);
        chk("d1_max_data", d1_max_data, 32'h40A0_0000);
        chk("d1_max_idx", {31'd0, d1_max_idx}, 32'd0);
        d1_out_ready = 1'b1;
        @(negedge clk);
        d1_out_ready = 1'b0;
        chk("d1_release", {31'd0, d1_out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
